piso_serializer: RTL
====================

# piso_serializer

Parallel-in serial-out transmitter: accepts a WIDTH-bit parallel word through a valid/ready handshake and shifts it out one bit per clock. A frame strobe marks each valid bit, and an end-of-word strobe marks the last bit. It sits on the far side of the team's parallel register stages and drives a single-wire serial link toward a serial-in receiver. Back-to-back words stream with no idle gap.

## Interface
- WIDTH, default 4: word width in bits; legal values are ≥ 1.
- MSB_FIRST, default 1: 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

- clock  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
- data  input  WIDTH  parallel word; sampled only on an accepted load.
- load  input  1  word valid from the upstream stage.
- ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data bit (registered).
- sframe  output  1  high while sout carries a valid bit (registered).
- last  output  1  high with the final bit of each word (registered).

## Operation
- States:
  - IDLE: no word in flight.
  - SHIFT: word in flight; bit counter cnt runs 0..WIDTH-1.
- ready = (state==IDLE) | (state==SHIFT & cnt==WIDTH-1). This is combinational from registered state only, with no path from load.
- A load is accepted when load & ready are high at a rising edge.
- On accept:
  - The word is captured into the shift register.
  - cnt ← 0.
  - state ← SHIFT.
- The first bit appears on sout in the next cycle.
- In SHIFT:
  - Each edge advances the shift register by one position and increments cnt.
  - At cnt==WIDTH-1 with no accept, state ← IDLE.
- Bit order:
  - MSB_FIRST=1: data[WIDTH-1], …, data[0].
  - MSB_FIRST=0: data[0], …, data[WIDTH-1].
- sframe is 1 exactly for the WIDTH cycles of each word.
- last is 1 in the cycle carrying the final bit.
- In IDLE, sout=0, sframe=0, last=0.
- load while ready=0 is ignored. The word in flight is unaffected, and nothing is queued.
- Once a word is accepted, changes on data have no effect on it.
- Reset values: state=IDLE, cnt=0, shift register=0, sout=0, sframe=0, last=0, hence ready=1.
- Reset mid-word: outputs clear asynchronously and the partial word is discarded. After release, the block accepts a load on the first rising edge.
- WIDTH=1: every SHIFT cycle is the last cycle, so ready stays 1 throughout and last=sframe.

## Timing
- Latency: a load accepted at edge t gives the first bit valid after edge t, for the cycle t..t+1. The final bit is in cycle t+WIDTH-1..t+WIDTH.
- Throughput is one word per WIDTH cycles.
- An accept in the last-bit cycle puts the next word's first bit in the immediately following cycle. sframe stays continuously high across the two words.
- All outputs except ready are flops. ready settles within the cycle from state and cnt.
- cnt width is max(1, $clog2(WIDTH)) bits. It never wraps past WIDTH-1; it is reloaded to 0 on accept.

## Structure
- Shared package shift_pkg holds:
  - state encoding constants ST_IDLE=1'b0 and ST_SHIFT=1'b1;
  - the default width constant WORD_W=4, shared with the parallel register stages.
- One sub-module, bit_counter: a parameterised up-counter with load-to-zero, enable, and terminal-count output. The FSM, shift register and output flops stay in piso_serializer.

## Test plan
Defaults WIDTH=4, MSB_FIRST=1 unless stated.

1. Reset: hold reset=0 for 2 cycles, with load=1 and data=4'b1111.
   - During reset: sout=0, sframe=0, last=0, ready=1.
   - After release: nothing is shifted until the first accepting edge.
2. Single word: load data=4'b1011 for one cycle in IDLE.
   - Next 4 cycles: sout=1,0,1,1, sframe=1,1,1,1, last=0,0,0,1.
   - ready=0,0,0,1, then the block returns to IDLE with sframe=0.
3. Back-to-back: present 4'b1100, then hold load=1 with 4'b0011 through the last-bit cycle.
   - sout=1,1,0,0,0,0,1,1 over 8 consecutive cycles.
   - sframe high all 8 cycles; last high in cycles 4 and 8.
4. Busy load: during bit 2 of word 4'b1001, pulse load with 4'b1111.
   - The pulse is ignored; sout remains 1,0,0,1.
   - Afterwards, IDLE with sframe=0.
5. Reset mid-word: assert reset after 2 bits of 4'b1010, then release and load 4'b0101.
   - sout and sframe drop to 0 asynchronously while reset is low.
   - New word outputs 0,1,0,1 with last on the 4th bit.
6. LSB-first, with MSB_FIRST=0 and WIDTH=4: load 4'b0001 then 4'b0110 back-to-back.
   - sout=1,0,0,0,0,1,1,0.
   - Repeat with WIDTH=1, loading 1,0,1 back-to-back: sout=1,0,1, with ready=1 and last=sframe throughout.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the serial shift stages: state encoding,
// default word width and counter sizing helper.
package shift_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    localparam int WORD_W = 4;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT
    } state_t;

    // Bit counter width: max(1, clog2(w)).
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel load handshake plus serial link for piso_serializer.
// slave: data/load in, ready/sout/sframe/last out; master mirrors it.
interface piso_serializer_if
    import shift_pkg::*;
#(
    parameter int WIDTH = WORD_W
) ();

    logic [WIDTH-1:0] data;
    logic             load;
    logic             ready;
    logic             sout;
    logic             sframe;
    logic             last;

    modport slave (
        input  data,
        input  load,
        output ready,
        output sout,
        output sframe,
        output last
    );

    modport master (
        output data,
        output load,
        input  ready,
        input  sout,
        input  sframe,
        input  last
    );

endinterface

// File: rtl/bit_counter.sv
// Up-counter 0..N-1 with clear-to-zero, enable and terminal count.
// Ports: clock, reset (async low), clr, en -> cnt, tc (cnt == N-1).
module bit_counter
    import shift_pkg::*;
#(
    parameter int N  = WORD_W,
    parameter int CW = cnt_width(N)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    assign tc = (cnt == CW'(N - 1));

    // Holds at N-1 rather than wrapping; clr has priority.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with frame and end-of-word strobes.
// Ports: clock, reset (async low), bus (slave: data/load -> ready/sout/sframe/last).
module piso_serializer
    import shift_pkg::*;
#(
    parameter int WIDTH     = WORD_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    piso_serializer_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);
    // Index of the second-to-last bit; only consulted when WIDTH > 1.
    localparam int PEN = (WIDTH > 1) ? WIDTH - 2 : 0;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic             sout_q;
    logic             sframe_q;
    logic             last_q;
    logic [CW-1:0]    cnt;
    logic             tc;
    logic             ready;
    logic             accept;
    logic             cnt_en;

    function automatic logic head(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? (v << 1) : (v >> 1);
    endfunction

    // Ready only depends on registered state, never on load.
    assign ready  = (state == S_IDLE) | ((state == S_SHIFT) & tc);
    assign accept = bus.load & ready;
    assign cnt_en = (state == S_SHIFT) & ~tc;

    bit_counter #(
        .N  (WIDTH),
        .CW (CW)
    ) u_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (accept),
        .en    (cnt_en),
        .cnt   (cnt),
        .tc    (tc)
    );

    // The first bit goes straight to sout on accept; sreg keeps the
    // remaining bits, aligned so head() always yields the next one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            sreg     <= '0;
            sout_q   <= 1'b0;
            sframe_q <= 1'b0;
            last_q   <= 1'b0;
        end else if (accept) begin
            state    <= S_SHIFT;
            sreg     <= adv(bus.data);
            sout_q   <= head(bus.data);
            sframe_q <= 1'b1;
            last_q   <= (WIDTH == 1);
        end else if (state == S_SHIFT) begin
            if (tc) begin
                state    <= S_IDLE;
                sout_q   <= 1'b0;
                sframe_q <= 1'b0;
                last_q   <= 1'b0;
            end else begin
                sreg   <= adv(sreg);
                sout_q <= head(sreg);
                last_q <= (cnt == CW'(PEN));
            end
        end
    end

    assign bus.ready  = ready;
    assign bus.sout   = sout_q;
    assign bus.sframe = sframe_q;
    assign bus.last   = last_q;

endmodule
